sample_seq_ctrl: RTL and testbench



---
 rtl/sample_pkg.sv | 23 ++
 rtl/sample_addr_ctr.sv | 21 ++
 rtl/sample_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_sample_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sample_pkg.sv
// Shared definitions for the sample capture sequencer: state encoding,
// default widths and databus status-word bit positions.
package sample_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    ARM  = 3'd2,
    DLY  = 3'd3,
    POST = 3'd4,
    DONE = 3'd5
  } seq_state_t;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 32;

  // Bit positions of the status word the MCU polls over the databus
  localparam int STAT_START_BIT = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_FULL_BIT  = 2;
  localparam int STAT_READY_BIT = 3;

endpackage

// File: rtl/sample_addr_ctr.sv
// Wrapping AW-bit address counter with clear > load > increment priority.
module sample_addr_ctr #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] ld_val,
  output logic [AW-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)    q <= '0;
    else if (clr)  q <= '0;
    else if (load) q <= ld_val;
    else if (inc)  q <= q + AW'(1);
  end

endmodule

// File: rtl/sample_seq_ctrl.sv
// Capture sequencer for the sample FIFO RAM: pre-fill, arm, delay, post-fill, readout.
// Optional auto-trigger timeout is enabled by defining AUTO_TRIG_EN.
module sample_seq_ctrl
  import sample_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
`ifdef AUTO_TRIG_EN
  , parameter logic [23:0] TIMEOUT = 24'hFFFFFF
`endif
) (
  input  logic          MCK,
  input  logic          nRST,
  input  logic          Start,
  input  logic          Sample_En,
  input  logic          Trigg,
  input  logic [AW-1:0] Depth,
  input  logic [AW-1:0] PerCnt,
  input  logic [DW-1:0] Delay,
  input  logic          Rd_Strobe,
  output logic          Wr_En,
  output logic [AW-1:0] Wr_Addr,
  output logic [AW-1:0] Rd_Addr,
  output logic [AW-1:0] Trig_Addr,
  output logic          Ready,
  output logic          Full,
  output logic          Empty,
  output logic          Busy
`ifdef AUTO_TRIG_EN
  , output logic        Auto_Trig
`endif
);

  seq_state_t    state, state_nxt;
  logic [AW-1:0] depth_q, pc_q, post_n_q;
  logic [DW-1:0] delay_q;
  logic [AW-1:0] cnt;
  logic [DW-1:0] dly_cnt;
  logic          fin_q;
  logic          wr_take, hit, auto_hit;
  logic          rd_load, rd_inc;
  logic [AW-1:0] depth_eff, pc_eff, wr_addr_nxt;

  // Depth=0 behaves as a single-sample capture; pre-count never consumes the whole depth
  assign depth_eff   = (Depth == '0) ? AW'(1) : Depth;
  assign pc_eff      = (PerCnt < depth_eff) ? PerCnt : depth_eff - AW'(1);
  assign wr_addr_nxt = Wr_Addr + AW'(Wr_En);
  assign hit         = Sample_En & (Trigg | auto_hit);

  assign Ready = (state == ARM);
  assign Full  = (state == DONE);
  assign Busy  = (state == PRE) || (state == ARM) || (state == DLY) || (state == POST);

  always_ff @(posedge MCK) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_take   = 1'b0;
    case (state)
      PRE: begin
        if (pc_q == '0) state_nxt = ARM;
        else begin
          wr_take = Sample_En;
          if (Sample_En && cnt == pc_q - AW'(1)) state_nxt = ARM;
        end
      end
      ARM: begin
        wr_take = Sample_En;
        if (hit) state_nxt = (delay_q == '0) ? POST : DLY;
      end
      DLY:  if (Sample_En && dly_cnt == delay_q - DW'(1)) state_nxt = POST;
      POST: begin
        wr_take = Sample_En & ~fin_q;
        if (fin_q) state_nxt = DONE;
      end
      default: ;
    endcase
    if (Start) begin
      state_nxt = PRE;
      wr_take   = 1'b0;
    end
  end

  // fin_q marks that the last post-trigger sample has been accepted; DONE follows its write pulse
  always_ff @(posedge MCK) begin
    if (!nRST) begin
      Wr_En     <= 1'b0;
      Trig_Addr <= '0;
      Empty     <= 1'b1;
      cnt       <= '0;
      dly_cnt   <= '0;
      fin_q     <= 1'b0;
      depth_q   <= '0;
      pc_q      <= '0;
      post_n_q  <= '0;
      delay_q   <= '0;
    end else if (Start) begin
      Wr_En    <= 1'b0;
      Empty    <= 1'b1;
      cnt      <= '0;
      dly_cnt  <= '0;
      fin_q    <= 1'b0;
      depth_q  <= depth_eff;
      pc_q     <= pc_eff;
      post_n_q <= depth_eff - pc_eff;
      delay_q  <= Delay;
    end else begin
      Wr_En <= wr_take;
      case (state)
        PRE: if (Sample_En && pc_q != '0) begin
          cnt <= (cnt == pc_q - AW'(1)) ? '0 : cnt + AW'(1);
        end
        ARM: if (hit) begin
          Trig_Addr <= wr_addr_nxt;
          dly_cnt   <= '0;
          if (delay_q == '0) begin
            cnt   <= AW'(1);
            fin_q <= (post_n_q == AW'(1));
          end else begin
            cnt <= '0;
          end
        end
        DLY: if (Sample_En) dly_cnt <= dly_cnt + DW'(1);
        POST: begin
          if (fin_q) begin
            cnt   <= '0;
            Empty <= 1'b0;
          end else if (Sample_En) begin
            cnt <= cnt + AW'(1);
            if (cnt == post_n_q - AW'(1)) fin_q <= 1'b1;
          end
        end
        DONE: if (Rd_Strobe && !Empty) begin
          cnt <= cnt + AW'(1);
          if (cnt == depth_q - AW'(1)) Empty <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_load = ~Start & (state == POST) & fin_q;
  assign rd_inc  = ~Start & (state == DONE) & Rd_Strobe & ~Empty;

  sample_addr_ctr #(.AW(AW)) u_wr_ctr (
    .clk    (MCK),
    .rst_n  (nRST),
    .clr    (Start),
    .load   (1'b0),
    .inc    (Wr_En),
    .ld_val ('0),
    .q      (Wr_Addr)
  );

  // Readout begins at the oldest pre-trigger sample
  sample_addr_ctr #(.AW(AW)) u_rd_ctr (
    .clk    (MCK),
    .rst_n  (nRST),
    .clr    (1'b0),
    .load   (rd_load),
    .inc    (rd_inc),
    .ld_val (Trig_Addr - pc_q),
    .q      (Rd_Addr)
  );

`ifdef AUTO_TRIG_EN
  logic [23:0] tmo_cnt;

  assign auto_hit = (tmo_cnt == TIMEOUT - 24'd1);

  always_ff @(posedge MCK) begin
    if (!nRST) begin
      tmo_cnt   <= '0;
      Auto_Trig <= 1'b0;
    end else if (Start) begin
      tmo_cnt   <= '0;
      Auto_Trig <= 1'b0;
    end else if (state == ARM && Sample_En) begin
      tmo_cnt <= tmo_cnt + 24'd1;
      if (auto_hit && !Trigg) Auto_Trig <= 1'b1;
    end
  end
`else
  assign auto_hit = 1'b0;
`endif

endmodule

// File: tb/tb_sample_seq_ctrl.sv
// Directed table-driven bench for sample_seq_ctrl (Sample_En held high throughout).
module tb_sample_seq_ctrl;

  logic        MCK = 1'b0;
  logic        nRST = 1'b0;
  logic        Start = 1'b0;
  logic        Sample_En = 1'b0;
  logic        Trigg = 1'b0;
  logic [11:0] Depth = '0;
  logic [11:0] PerCnt = '0;
  logic [31:0] Delay = '0;
  logic        Rd_Strobe = 1'b0;
  logic        Wr_En;
  logic [11:0] Wr_Addr, Rd_Addr, Trig_Addr;
  logic        Ready, Full, Empty, Busy;
`ifdef AUTO_TRIG_EN
  logic        Auto_Trig;
`endif

  int n_tests = 0;
  int n_fail  = 0;

`ifdef AUTO_TRIG_EN
  sample_seq_ctrl #(.TIMEOUT(24'd10)) dut (
`else
  sample_seq_ctrl dut (
`endif
    .MCK(MCK), .nRST(nRST), .Start(Start), .Sample_En(Sample_En), .Trigg(Trigg),
    .Depth(Depth), .PerCnt(PerCnt), .Delay(Delay), .Rd_Strobe(Rd_Strobe),
    .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Rd_Addr(Rd_Addr), .Trig_Addr(Trig_Addr),
    .Ready(Ready), .Full(Full), .Empty(Empty), .Busy(Busy)
`ifdef AUTO_TRIG_EN
    , .Auto_Trig(Auto_Trig)
`endif
  );

  always #5 MCK = ~MCK;

  typedef struct {
    logic [11:0] depth;
    logic [11:0] percnt;
    logic [31:0] delay;
    int          trig_strobe;  // ARM strobe (1-based) carrying Trigg; 0 = never
    bit          trig_pre;     // hold Trigg high throughout PRE
    bit          chk_gap;
    bit          partial;      // read 3 samples then restart with a concurrent Rd_Strobe
    bit          exp_auto;
    int          exp_pre_cyc;
    int          exp_writes;
    logic [11:0] exp_trig;
    logic [11:0] exp_rd0;
    logic [11:0] exp_rd_end;
    int          n_rd;
  } cap_t;

  cap_t vecs[$];

  function automatic cap_t mk(input int d, input int p, input int dl, input int ts,
                              input bit tp, input bit cg, input bit pa, input bit au,
                              input int pc, input int wr, input int tr, input int r0,
                              input int re, input int nr);
    cap_t c;
    c.depth = 12'(d); c.percnt = 12'(p); c.delay = 32'(dl);
    c.trig_strobe = ts; c.trig_pre = tp; c.chk_gap = cg; c.partial = pa; c.exp_auto = au;
    c.exp_pre_cyc = pc; c.exp_writes = wr; c.exp_trig = 12'(tr);
    c.exp_rd0 = 12'(r0); c.exp_rd_end = 12'(re); c.n_rd = nr;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_cap(input cap_t v, input int idx);
    int  nwr, arm_cnt, pre_cyc, trig_cyc, t_w, n_w, nrd;
    bit  armed, done;
    Depth = v.depth; PerCnt = v.percnt; Delay = v.delay;
    Trigg = 1'b0; Sample_En = 1'b1; Rd_Strobe = 1'b0;
    @(negedge MCK); Start = 1'b1;
    @(negedge MCK); Start = 1'b0;
    // Configuration must have been latched on Start
    Depth = ~v.depth; PerCnt = ~v.percnt; Delay = 32'd7;
    chk($sformatf("v%0d_entry_flags", idx), {27'd0, Busy, Ready, Full, Empty, Wr_En}, 32'b10010);
    chk($sformatf("v%0d_entry_wraddr", idx), 32'(Wr_Addr), 32'd0);

    nwr = 0; arm_cnt = 0; pre_cyc = 0; trig_cyc = -1; t_w = -1; n_w = -1;
    armed = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      if (Full) done = 1'b1;
      else begin
        if (Wr_En) begin
          nwr++;
          if (trig_cyc >= 0 && cyc == trig_cyc + 1) t_w = cyc;
          else if (t_w >= 0 && n_w < 0) n_w = cyc;
        end
        if (Ready) begin
          armed = 1'b1;
          arm_cnt++;
        end else if (!armed) pre_cyc++;
        Trigg = armed ? (Ready && arm_cnt == v.trig_strobe) : v.trig_pre;
        if (Trigg && armed) trig_cyc = cyc;
        @(negedge MCK);
      end
    end
    Trigg = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL v%0d_full_timeout: Full=0 after 20000 cycles, required 1", idx);
      return;
    end

    chk($sformatf("v%0d_trig_addr", idx), 32'(Trig_Addr), 32'(v.exp_trig));
    chk($sformatf("v%0d_rd_start", idx), 32'(Rd_Addr), 32'(v.exp_rd0));
    chk($sformatf("v%0d_writes", idx), 32'(nwr), 32'(v.exp_writes));
    chk($sformatf("v%0d_pre_cycles", idx), 32'(pre_cyc), 32'(v.exp_pre_cyc));
    chk($sformatf("v%0d_done_flags", idx), {27'd0, Busy, Ready, Full, Empty, Wr_En}, 32'b00100);
    if (v.chk_gap) chk($sformatf("v%0d_delay_gap", idx), 32'(n_w - t_w - 1), v.delay);
`ifdef AUTO_TRIG_EN
    chk($sformatf("v%0d_auto_trig", idx), {31'd0, Auto_Trig}, {31'd0, v.exp_auto});
`endif

    Rd_Strobe = 1'b1;
    if (v.partial) begin
      repeat (3) @(negedge MCK);
      Start = 1'b1;
      @(negedge MCK);
      Start = 1'b0; Rd_Strobe = 1'b0;
      chk($sformatf("v%0d_restart_rdaddr", idx), 32'(Rd_Addr), 32'(v.exp_rd_end));
      chk($sformatf("v%0d_restart_wraddr", idx), 32'(Wr_Addr), 32'd0);
      chk($sformatf("v%0d_restart_flags", idx), {28'd0, Busy, Ready, Full, Empty}, 32'b1001);
    end else begin
      nrd = v.n_rd;
      repeat (nrd - 1) @(negedge MCK);
      chk($sformatf("v%0d_empty_before_last", idx), {31'd0, Empty}, 32'd0);
      @(negedge MCK);
      Rd_Strobe = 1'b0;
      chk($sformatf("v%0d_empty_after_all", idx), {31'd0, Empty}, 32'd1);
      chk($sformatf("v%0d_rd_end", idx), 32'(Rd_Addr), 32'(v.exp_rd_end));
      Rd_Strobe = 1'b1;
      @(negedge MCK);
      Rd_Strobe = 1'b0;
      chk($sformatf("v%0d_rd_extra_ignored", idx), 32'(Rd_Addr), 32'(v.exp_rd_end));
    end
  endtask

  initial begin
    //             dep  per  dly  trig  pre gap part auto pcyc  wr    trig rd0  rdend nrd
    vecs.push_back(mk(16,   4,   0,    3, 1,  1,  0,  0,   4,   18,    6,   2,   18,  16));
    vecs.push_back(mk(8,    2,   5,    1, 0,  1,  0,  0,   2,    9,    2,   0,    8,   8));
`ifndef AUTO_TRIG_EN
    vecs.push_back(mk(4095, 100, 0, 5001, 0,  1,  0,  0, 100, 9095, 1004, 904,  903, 4095));
`endif
    vecs.push_back(mk(10,  20,   0,    1, 1,  0,  0,  0,   9,   10,    9,   0,   10,  10));
    vecs.push_back(mk(0,    5,   3,    2, 0,  1,  0,  0,   1,    3,    1,   1,    2,   1));
    vecs.push_back(mk(5,    0,   0,    1, 0,  1,  1,  0,   1,    5,    0,   0,    3,   5));
`ifdef AUTO_TRIG_EN
    vecs.push_back(mk(8,    2,   0,    0, 0,  0,  0,  1,   2,   17,   11,   9,   17,   8));
    vecs.push_back(mk(8,    2,   0,   10, 0,  1,  0,  0,   2,   17,   11,   9,   17,   8));
`endif

    nRST = 1'b0;
    repeat (2) @(negedge MCK);
    chk("reset_flags", {27'd0, Wr_En, Ready, Full, Empty, Busy}, 32'b00010);
    chk("reset_wraddr", 32'(Wr_Addr), 32'd0);
    chk("reset_rdaddr", 32'(Rd_Addr), 32'd0);
    chk("reset_trigaddr", 32'(Trig_Addr), 32'd0);
    nRST = 1'b1;
    @(negedge MCK);

    for (int i = 0; i < vecs.size(); i++) run_cap(vecs[i], i);

    // Restart while counting the post-trigger delay
    Depth = 12'd8; PerCnt = 12'd2; Delay = 32'd50; Sample_En = 1'b1; Trigg = 1'b0;
    @(negedge MCK); Start = 1'b1;
    @(negedge MCK); Start = 1'b0;
    for (int i = 0; i < 100 && !Ready; i++) @(negedge MCK);
    chk("dly_restart_armed", {31'd0, Ready}, 32'd1);
    Trigg = 1'b1;
    @(negedge MCK);
    Trigg = 1'b0;
    repeat (3) @(negedge MCK);
    chk("dly_restart_in_dly", {28'd0, Busy, Ready, Full, Wr_En}, 32'b1000);
    chk("dly_restart_wraddr_before", 32'(Wr_Addr), 32'd3);
    Start = 1'b1;
    @(negedge MCK);
    Start = 1'b0;
    chk("dly_restart_flags", {28'd0, Busy, Ready, Full, Empty}, 32'b1001);
    chk("dly_restart_wraddr", 32'(Wr_Addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
